// File: rtl/fft_peak_finder.sv
// Finds the two strongest local peaks of one FFT magnitude frame within [MIN_BIN, MAX_BIN]
// and reports their bins, magnitudes and the strongest peak's frequency once per frame.
module fft_peak_finder #(
  parameter int unsigned N_POINTS = 1024,
  parameter int unsigned LOG2_N   = 10,
  parameter int unsigned FS_HZ    = 500000,
  parameter int unsigned MIN_BIN  = 1,
  parameter int unsigned MAX_BIN  = 511
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [27:0]       mag_threshold,
  input  logic [27:0]       magnitude,
  input  logic [LOG2_N-1:0] bin_index,
  input  logic              magnitude_valid,
  output logic [LOG2_N-1:0] peak1_bin,
  output logic [27:0]       peak1_mag,
  output logic [LOG2_N-1:0] peak2_bin,
  output logic [27:0]       peak2_mag,
  output logic [31:0]       peak1_freq_hz,
  output logic [1:0]        peak_count,
  output logic              result_valid,
  output logic              frame_error,
  output logic              busy
);

  typedef logic [LOG2_N-1:0] bin_t;
  typedef logic [27:0]       mag_t;
  typedef struct packed {
    bin_t b1;
    mag_t m1;
    bin_t b2;
    mag_t m2;
  } peaks_t;

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  localparam logic [18:0] FsW     = 19'(FS_HZ);
  localparam bin_t        LastBin = bin_t'(N_POINTS - 1);

  function automatic logic is_peak(mag_t l, mag_t c, mag_t r, mag_t thr, bin_t k);
    return (l < c) && (c >= r) && (c > thr) &&
           (32'(k) >= MIN_BIN) && (32'(k) <= MAX_BIN);
  endfunction

  // Strictly-greater replacement keeps the lower bin on ties, since bins arrive ascending.
  function automatic peaks_t rank(peaks_t p, logic hit, bin_t k, mag_t m);
    peaks_t r;
    r = p;
    if (hit) begin
      if (m > p.m1) begin
        r.b2 = p.b1;
        r.m2 = p.m1;
        r.b1 = k;
        r.m1 = m;
      end else if (m > p.m2) begin
        r.b2 = k;
        r.m2 = m;
      end
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  bin_t        exp_q, exp_d;
  mag_t        m_km1_q, m_km1_d, m_k_q, m_k_d;
  peaks_t      trk_q, trk_d, res_q, res_d, trk_a, trk_b;
  logic        rep_mul_q, rep_reg_q, launch, err_d, start;
  logic [31:0] prod_q;
  bin_t        k_prev;

  assign start  = magnitude_valid && enable && (bin_index == '0);
  assign k_prev = bin_index - bin_t'(1);

  // Candidate k-1 uses the incoming bin as right neighbour; candidate k (last bin only) sees 0.
  always_comb begin
    trk_a = rank(trk_q, is_peak(m_km1_q, m_k_q, magnitude, mag_threshold, k_prev),
                 k_prev, m_k_q);
    trk_b = rank(trk_a, is_peak(m_k_q, magnitude, '0, mag_threshold, bin_index),
                 bin_index, magnitude);
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    m_km1_d = m_km1_q;
    m_k_d   = m_k_q;
    trk_d   = trk_q;
    res_d   = res_q;
    launch  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle, StReport: begin
        if (start) begin
          state_d = StScan;
          exp_d   = bin_t'(1);
          trk_d   = '0;
          m_km1_d = '0;
          m_k_d   = magnitude;
        end else if (state_q == StReport && rep_reg_q) begin
          state_d = StIdle;
        end
      end
      StScan: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (magnitude_valid) begin
          if (bin_index == exp_q) begin
            trk_d   = trk_a;
            m_km1_d = m_k_q;
            m_k_d   = magnitude;
            exp_d   = exp_q + bin_t'(1);
            if (exp_q == LastBin) begin
              res_d   = trk_b;
              launch  = 1'b1;
              state_d = StReport;
            end
          end else begin
            err_d = 1'b1;
            trk_d = '0;
            if (bin_index == '0) begin
              exp_d   = bin_t'(1);
              m_km1_d = '0;
              m_k_d   = magnitude;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      exp_q         <= '0;
      m_km1_q       <= '0;
      m_k_q         <= '0;
      trk_q         <= '0;
      res_q         <= '0;
      rep_mul_q     <= 1'b0;
      rep_reg_q     <= 1'b0;
      prod_q        <= '0;
      peak1_bin     <= '0;
      peak1_mag     <= '0;
      peak2_bin     <= '0;
      peak2_mag     <= '0;
      peak1_freq_hz <= '0;
      peak_count    <= '0;
      result_valid  <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      m_km1_q      <= m_km1_d;
      m_k_q        <= m_k_d;
      trk_q        <= trk_d;
      res_q        <= res_d;
      rep_mul_q    <= launch;
      rep_reg_q    <= rep_mul_q;
      result_valid <= rep_reg_q;
      frame_error  <= err_d;
      if (rep_mul_q) begin
        prod_q <= 32'(res_q.b1) * 32'(FsW);
      end
      if (rep_reg_q) begin
        peak1_bin     <= res_q.b1;
        peak1_mag     <= res_q.m1;
        peak2_bin     <= res_q.b2;
        peak2_mag     <= res_q.m2;
        peak1_freq_hz <= prod_q >> LOG2_N;
        // Real peaks always exceed the threshold, so a zero magnitude marks an empty slot.
        peak_count    <= 2'(res_q.m1 != '0) + 2'(res_q.m2 != '0);
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: tones, ties, range edges, sequence faults, async reset
// and back-to-back frames, with hand-computed expectations.
module tb_fft_peak_finder;

  logic        clk = 1'b0;
  logic        rst, enable, magnitude_valid;
  logic [27:0] mag_threshold, magnitude;
  logic [9:0]  bin_index;
  logic [9:0]  peak1_bin, peak2_bin;
  logic [27:0] peak1_mag, peak2_mag;
  logic [31:0] peak1_freq_hz;
  logic [1:0]  peak_count;
  logic        result_valid, frame_error, busy;

  fft_peak_finder dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .mag_threshold  (mag_threshold),
    .magnitude      (magnitude),
    .bin_index      (bin_index),
    .magnitude_valid(magnitude_valid),
    .peak1_bin      (peak1_bin),
    .peak1_mag      (peak1_mag),
    .peak2_bin      (peak2_bin),
    .peak2_mag      (peak2_mag),
    .peak1_freq_hz  (peak1_freq_hz),
    .peak_count     (peak_count),
    .result_valid   (result_valid),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  logic [27:0] spec [1024];
  int n_total = 0, n_bad = 0;
  int cyc = 0, rv_cnt = 0, err_cnt = 0, rv_cyc = 0, last_cyc = 0;
  int rv0, err0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid) begin
      rv_cnt = rv_cnt + 1;
      rv_cyc = cyc;
    end
    if (frame_error) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int b1, input int m1, input int b2,
                           input int m2, input int freq, input int cnt);
    check({tag, ".peak1_bin"}, 32'(peak1_bin), b1);
    check({tag, ".peak1_mag"}, 32'(peak1_mag), m1);
    check({tag, ".peak2_bin"}, 32'(peak2_bin), b2);
    check({tag, ".peak2_mag"}, 32'(peak2_mag), m2);
    check({tag, ".freq"}, peak1_freq_hz, freq);
    check({tag, ".count"}, 32'(peak_count), cnt);
  endtask

  task automatic fill(input logic [27:0] base);
    for (int i = 0; i < 1024; i++) spec[i] = base;
  endtask

  task automatic send_bins(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge clk); #1;
      magnitude       = spec[i];
      bin_index       = 10'(i);
      magnitude_valid = 1'b1;
      last_cyc        = cyc;
    end
    @(posedge clk); #1;
    magnitude_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    enable          = 1'b1;
    mag_threshold   = 28'h10000;
    magnitude       = '0;
    bin_index       = '0;
    magnitude_valid = 1'b0;
    idle(3);
    check_res("reset", 0, 0, 0, 0, 0, 0);
    check("reset.valid", 32'(result_valid), 0);
    check("reset.busy", 32'(busy), 0);
    rst = 1'b0;

    // Single tone
    fill(28'h1000);
    spec[123] = 28'h2000000;
    rv0 = rv_cnt;
    send_bins(0, 1023);
    idle(6);
    check("tone.pulses", rv_cnt - rv0, 1);
    check("tone.latency", rv_cyc - last_cyc, 3);
    check_res("tone", 123, 'h2000000, 0, 0, 60058, 1);
    check("tone.busy", 32'(busy), 0);

    // Two tones, then swapped strengths
    spec[369] = 28'h300000;
    send_bins(0, 1023);
    idle(6);
    check_res("two", 123, 'h2000000, 369, 'h300000, 60058, 2);
    spec[123] = 28'h300000;
    spec[369] = 28'h2000000;
    send_bins(0, 1023);
    idle(6);
    check_res("swap", 369, 'h2000000, 123, 'h300000, 180175, 2);

    // Equal peaks, huge DC, out-of-range bin
    fill(28'h1000);
    spec[40]  = 28'h500000;
    spec[80]  = 28'h500000;
    spec[0]   = 28'hFFFFFFF;
    spec[600] = 28'h8000000;
    send_bins(0, 1023);
    idle(6);
    check_res("ties", 40, 'h500000, 80, 'h500000, 19531, 2);

    // Sequence fault, then a clean frame
    fill(28'h1000);
    spec[123] = 28'h2000000;
    rv0  = rv_cnt;
    err0 = err_cnt;
    send_bins(0, 99);
    send_bins(200, 200);
    idle(5);
    check("fault.errors", err_cnt - err0, 1);
    check("fault.pulses", rv_cnt - rv0, 0);
    check("fault.busy", 32'(busy), 0);
    check("fault.hold", 32'(peak1_bin), 40);
    send_bins(0, 1023);
    idle(6);
    check("fault.next_pulses", rv_cnt - rv0, 1);
    check_res("fault.next", 123, 'h2000000, 0, 0, 60058, 1);

    // Async reset mid-frame
    spec[369] = 28'h300000;
    send_bins(0, 500);
    #2;
    rst = 1'b1;
    #1;
    check_res("arst", 0, 0, 0, 0, 0, 0);
    check("arst.busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_bins(0, 1023);
    idle(6);
    check_res("arst.next", 123, 'h2000000, 369, 'h300000, 60058, 2);

    // Flat below threshold, back-to-back frames with a 1-cycle gap
    fill(28'h1000);
    rv0  = rv_cnt;
    err0 = err_cnt;
    send_bins(0, 1023);
    send_bins(0, 1023);
    idle(6);
    check("b2b.pulses", rv_cnt - rv0, 2);
    check("b2b.errors", err_cnt - err0, 0);
    check_res("flat", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
